// File: rtl/dn_pkg.sv
// Shared types and sizing helpers for the Benes config loader slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dn_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } dn_state_e;

  // Number of Benes stages for an n-wide network
  function automatic int n_levels(input int n);
    return 2 * $clog2(n) - 1;
  endfunction

  // Total route-bit width: 2 bits per router, n/2 routers per stage
  function automatic int route_w(input int n);
    return 2 * n_levels(n) * (n / 2);
  endfunction

  localparam int DEF_N        = 32;
  localparam int DEF_N_LEVELS = n_levels(DEF_N);
  localparam int ROUTE_W      = route_w(DEF_N);

endpackage

// File: rtl/dn_benes_cfg_loader_if.sv
// Config, batch-control, vector and network-side signals of the loader.
// Latency: n/a (wiring only).
// Backpressure: cfg_ready and vec_ready are the only upstream throttles.
interface dn_benes_cfg_loader_if
  import dn_pkg::*;
#(
  parameter int N       = 32,
  parameter int DW_DATA = 8,
  parameter int CNT_W   = 11,
  parameter int ROUTE_W = route_w(N)
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [N-1:0]         cfg_data;
  logic                 start;
  logic [CNT_W-1:0]     num_vec;
  logic                 vec_valid;
  logic                 vec_ready;
  logic [DW_DATA*N-1:0] vec_data;
  logic                 set_en;
  logic                 route_en;
  logic [ROUTE_W-1:0]   route_signals;
  logic [DW_DATA*N-1:0] dn_in;
  logic                 dn_in_valid;
  logic                 busy;
  logic                 done;
  logic                 err_start;

  // Upstream controller / operand source side
  modport master (
    output cfg_valid, cfg_data, start, num_vec, vec_valid, vec_data,
    input  cfg_ready, vec_ready, set_en, route_en, route_signals,
           dn_in, dn_in_valid, busy, done, err_start
  );

  // Loader side
  modport slave (
    input  cfg_valid, cfg_data, start, num_vec, vec_valid, vec_data,
    output cfg_ready, vec_ready, set_en, route_en, route_signals,
           dn_in, dn_in_valid, busy, done, err_start
  );
endinterface

// File: rtl/dn_cfg_shadow.sv
// Shadow buffer collecting one route word per Benes level, level 0 first.
// Latency: a written word is visible on shadow_o the cycle after acceptance.
// Backpressure: full_o stays high once all levels are loaded until clear_i.
module dn_cfg_shadow
  import dn_pkg::*;
#(
  parameter  int N        = 32,
  parameter  int N_LEVELS = n_levels(32),
  localparam int SH_W     = N_LEVELS * N,
  localparam int LVL_W    = $clog2(N_LEVELS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_vld_i,
  input  logic [N-1:0]    wr_dat_i,
  input  logic            clear_i,
  output logic            full_o,
  output logic [SH_W-1:0] shadow_o
);
  logic [LVL_W-1:0] lvl_cnt_q;
  logic [SH_W-1:0]  shadow_q;
  logic             wr_acc;

  assign full_o   = (lvl_cnt_q == LVL_W'(N_LEVELS));
  assign wr_acc   = wr_vld_i & ~full_o;
  assign shadow_o = shadow_q;

  // Write the next level slot on each accepted beat; clear rewinds the counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_cnt_q <= '0;
      shadow_q  <= '0;
    end else if (clear_i) begin
      lvl_cnt_q <= '0;
    end else if (wr_acc) begin
      shadow_q[int'(lvl_cnt_q) * N +: N] <= wr_dat_i;
      lvl_cnt_q                         <= lvl_cnt_q + LVL_W'(1);
    end
  end
endmodule

// File: rtl/dn_benes_cfg_loader.sv
// Loads Benes route config via a shadow buffer, commits it, then streams a counted batch.
// Latency: route_signals valid 1 cycle after SET; dn_in 1 cycle after vector acceptance.
// Backpressure: cfg_ready low while shadow full; vec_ready high only in RUN, stalls on vec_valid=0.
module dn_benes_cfg_loader
  import dn_pkg::*;
#(
  parameter int N        = 32,
  parameter int DW_DATA  = 8,
  parameter int N_LEVELS = n_levels(N),
  parameter int MAX_VEC  = 1024,
  parameter int CNT_W    = $clog2(MAX_VEC + 1)
) (
  input logic                  clk,
  input logic                  reset,
  dn_benes_cfg_loader_if.slave bus
);
  localparam int               ROUTE_W = 2 * N_LEVELS * (N / 2);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VEC);

  dn_state_e            state_q;
  logic [CNT_W-1:0]     num_q;
  logic [CNT_W-1:0]     num_d;
  logic [CNT_W-1:0]     vec_cnt_q;
  logic [CNT_W-1:0]     vec_cnt_d;
  logic [ROUTE_W-1:0]   route_q;
  logic [ROUTE_W-1:0]   shadow_vec;
  logic [DW_DATA*N-1:0] dn_in_q;
  logic                 set_en_q;
  logic                 route_en_q;
  logic                 vec_ready_q;
  logic                 dn_in_valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_start_q;
  logic                 shadow_full;
  logic                 shadow_clear;
  logic                 vec_acc;

  // The shadow is rewound during SET; no beat can land then because cfg_ready is low
  assign shadow_clear = (state_q == ST_SET);
  assign vec_acc      = bus.vec_valid & vec_ready_q;
  assign num_d        = (bus.num_vec > MAX_CNT) ? MAX_CNT : bus.num_vec;
  assign vec_cnt_d    = vec_cnt_q + CNT_W'(1);

  dn_cfg_shadow #(
    .N        (N),
    .N_LEVELS (N_LEVELS)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_vld_i (bus.cfg_valid),
    .wr_dat_i (bus.cfg_data),
    .clear_i  (shadow_clear),
    .full_o   (shadow_full),
    .shadow_o (shadow_vec)
  );

  // Batch FSM with registered strobes, route commit and the 1-deep vector register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      num_q         <= '0;
      vec_cnt_q     <= '0;
      route_q       <= '0;
      dn_in_q       <= '0;
      set_en_q      <= 1'b0;
      route_en_q    <= 1'b0;
      vec_ready_q   <= 1'b0;
      dn_in_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_start_q   <= 1'b0;
    end else begin
      set_en_q      <= 1'b0;
      done_q        <= 1'b0;
      err_start_q   <= 1'b0;
      dn_in_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (shadow_full) begin
              num_q     <= num_d;
              vec_cnt_q <= '0;
              set_en_q  <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= ST_SET;
            end else begin
              err_start_q <= 1'b1;
            end
          end
        end
        ST_SET: begin
          route_q    <= shadow_vec;
          route_en_q <= 1'b1;
          if (num_q != '0) begin
            vec_ready_q <= 1'b1;
            state_q     <= ST_RUN;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (vec_acc) begin
            dn_in_q       <= bus.vec_data;
            dn_in_valid_q <= 1'b1;
            vec_cnt_q     <= vec_cnt_d;
            if (vec_cnt_d == num_q) begin
              vec_ready_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          route_en_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready     = ~shadow_full;
  assign bus.vec_ready     = vec_ready_q;
  assign bus.set_en        = set_en_q;
  assign bus.route_en      = route_en_q;
  assign bus.route_signals = route_q;
  assign bus.dn_in         = dn_in_q;
  assign bus.dn_in_valid   = dn_in_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_start     = err_start_q;
endmodule

// File: doc/dn_benes_cfg_loader.md
Name: dn_benes_cfg_loader

Overview:
- Control and ingress stage directly upstream of the Benes distribution network (dn_benes) in the unstructured sparse path.
- Accepts per-level route configuration words into a shadow buffer, then commits them to the network's route_signals and pulses set_en.
- Streams a counted batch of operand vectors into the network with route_en held, then signals completion.
- The shadow buffer lets the next configuration load while the current batch runs.

Parameters:
- N, 32, network width in elements (power of 2, >=4).
- DW_DATA, 8, element width in bits.
- N_LEVELS, 2*$clog2(N)-1, Benes stages.
- MAX_VEC, 1024, maximum vectors per batch.
- CNT_W, $clog2(MAX_VEC+1), batch counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when valid&ready.
- cfg_data  in  N  one level's route bits: 2 bits per router, N/2 routers; level 0 is sent first.
- start  in  1  batch start request, sampled in IDLE only.
- num_vec  in  CNT_W  batch length, latched with start.
- vec_valid  in  1  operand vector valid.
- vec_ready  out  1  operand vector accepted when valid&ready.
- vec_data  in  DW_DATA*N  operand vector.
- set_en  out  1  network config strobe.
- route_en  out  1  network route enable.
- route_signals  out  2*N_LEVELS*(N/2)  active config; level L occupies bits [L*N +: N].
- dn_in  out  DW_DATA*N  vector to network.
- dn_in_valid  out  1  dn_in holds a new vector.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle batch-complete pulse.
- err_start  out  1  one-cycle pulse: start was ignored.

Behaviour:
- Reset (reset=0, async): state=IDLE, shadow count=0. All outputs 0 except cfg_ready=1. route_signals=0 and dn_in=0.
- Shadow buffer:
  - N_LEVELS words plus level counter lvl_cnt (0..N_LEVELS).
  - shadow_full = (lvl_cnt==N_LEVELS).
  - cfg_ready = !shadow_full, in every state.
  - An accepted beat writes word lvl_cnt, then lvl_cnt++.
- FSM states: IDLE, SET, RUN, DONE.
- IDLE:
  - start & shadow_full: latch num_vec, go to SET.
  - start & !shadow_full: pulse err_start next cycle, stay in IDLE.
- SET (exactly 1 cycle):
  - set_en=1.
  - route_signals <= shadow contents, registered and visible the cycle after SET.
  - lvl_cnt <= 0.
  - No cfg conflict is possible because cfg_ready=0 while the shadow is full.
  - Next state: RUN if the latched num_vec>0, else DONE.
- RUN:
  - route_en=1, vec_ready=1.
  - Each accepted vector registers into dn_in with dn_in_valid=1 the following cycle (1-cycle latency). dn_in_valid=0 on cycles with no acceptance; dn_in holds its value.
  - vec_cnt increments per acceptance.
  - On the acceptance that makes vec_cnt==num_vec: vec_ready drops the next cycle and the FSM goes to DONE.
  - Back-pressure from vec_valid=0 simply stalls the count.
- DONE (1 cycle):
  - done=1.
  - route_en stays 1 so the final dn_in vector is routed.
  - Next state: IDLE.
- route_signals holds its value until the next SET. Config words loaded during RUN or DONE do not disturb it.
- start outside IDLE is ignored without err_start.
- num_vec>MAX_VEC is clamped to MAX_VEC.
- Reset asserted mid-batch aborts immediately to reset values. A partially loaded shadow is discarded.

Decomposition:
- Package dn_pkg:
  - FSM state enum (2-bit).
  - Localparam function computing N_LEVELS from N.
  - Localparam ROUTE_W = 2*N_LEVELS*(N/2).
- Sub-module dn_cfg_shadow:
  - Holds the level counter, shadow array and write port.
  - Exports shadow_full and the flattened shadow vector.
  - Has a clear input driven in SET.
- Top-level keeps the FSM, batch counter and data register.

Test Plan:
- All tests use N=8, N_LEVELS=5, ROUTE_W=40.
- Load then run: feed 5 beats 0x01..0x05 with cfg_valid held, then start with num_vec=3 and 3 back-to-back vectors. Required: cfg_ready=0 after the 5th beat; set_en high for 1 cycle; route_signals=0x0504030201; dn_in_valid high for 3 cycles with data matching the inputs, delayed by 1; done pulses once; busy falls after done.
- Premature start: start after only 3 of 5 config beats. Required: err_start pulses for 1 cycle, no set_en, state stays IDLE; after 2 more beats a start succeeds.
- Double buffering: during a RUN with num_vec=4, load a second config 0xAA..0xEE. Required: route_signals unchanged until the next SET, then equals 0xEEDDCCBBAA; cfg_ready=0 after the 5th new beat.
- Back-pressure: num_vec=4 with vec_valid toggling 1,0,1,0,1,1. Required: exactly 4 acceptances, 4 dn_in_valid pulses, done one cycle after the 4th acceptance.
- Zero batch: start with num_vec=0. Required: SET → DONE, done=1 with no dn_in_valid, vec_ready never 1.
- Reset mid-run: assert reset after 2 of 5 vectors. Required: all outputs at reset values asynchronously, cfg_ready=1, and the next run requires a full 5-beat reload.
